liteic_rr_arbiter: RTL

- Round-robin arbiter sharing one liteic slave port between NUM_MASTERS requesters.
- Sits behind the address decoder, one instance per slave region.
- Decoder region-select bits, qualified by each master's valid, form req_i.
- Grant is held for a whole transaction until the slave-side done_i. The priority pointer then rotates past the served master.

---
 rtl/liteic_rr_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/liteic_rr_arbiter.sv
// liteic_rr_arbiter
// Round-robin arbiter that shares one liteic slave port between NUM_MASTERS
// requesters. A grant is held for a whole transaction until done_i. The
// priority pointer then moves past the master that was just served.
//
// Optional feature: define LITEIC_ARB_TIMEOUT_EN to build a BUSY watchdog.
// The watchdog force-releases a grant after TIMEOUT_CYCLES cycles without
// done_i. Without the macro, no counter is built and timeout_o is tied to 0.
module liteic_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic [NUM_MASTERS-1:0]         req_i,
  input  logic                           done_i,
  output logic [NUM_MASTERS-1:0]         gnt_o,
  output logic [$clog2(NUM_MASTERS)-1:0] gnt_idx_o,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int IW = $clog2(NUM_MASTERS);

  // One extra bit, so that start + offset (at most 2N-2) never overflows
  // before the explicit modulo compare.
  localparam logic [IW:0]   N_W     = (IW+1)'(NUM_MASTERS);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          last_q, last_d;
  logic                   timeout_q, timeout_d;

  // Arbitration signals
  logic [IW:0]            start_w;
  logic [IW:0]            cand_w;
  logic [IW-1:0]          win_idx;
  logic                   win_found;
  logic [NUM_MASTERS-1:0] win_onehot;

  // Release request from the watchdog (always 0 when it is not built)
  logic                   force_rel;

  // Search for the first requester at or after last_q+1, wrapping modulo N.
  // The wrap is an explicit compare, so non-power-of-two N is supported.
  always_comb begin
    start_w   = '0;
    cand_w    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    if (last_q == LAST_RST) begin
      start_w = '0;
    end else begin
      start_w = {1'b0, last_q} + (IW+1)'(1);
    end
    for (int off = 0; off < NUM_MASTERS; off++) begin
      cand_w = start_w + (IW+1)'(off);
      if (cand_w >= N_W) begin
        cand_w = cand_w - N_W;
      end
      if (!win_found && req_i[cand_w[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_w[IW-1:0];
      end
    end
  end

  // One-hot decode of the winning index
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == IW'(gi));
    end
  endgenerate

`ifdef LITEIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The watchdog fires on the last allowed BUSY cycle. A done_i in the same
  // cycle wins, so the release is then treated as a normal one.
  assign force_rel = (state_q == ST_BUSY) && !done_i && (cnt_q == CNT_LAST);

  // Counter is held at 0 in IDLE, so it starts at 0 on the first BUSY cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (!done_i && !force_rel) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  // Next-state logic: grant in IDLE, freeze in BUSY, release on done or timeout
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_BUSY;
          gnt_d   = win_onehot;
          idx_d   = win_idx;
        end
      end
      ST_BUSY: begin
        if (done_i || force_rel) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          last_d    = idx_q;
          timeout_d = force_rel;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, grant and pointer registers. Reset drops the grant immediately.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= LAST_RST;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign busy_o    = (state_q == ST_BUSY);
  assign timeout_o = timeout_q;

endmodule
